// File: rtl/elastic_pipe.sv
// rtl/elastic_pipe.sv - DEPTH-stage registered pipeline with valid/ready, flush and occupancy count
// Each stage loads from upstream whenever it is empty or its own word is moving on.
module elastic_pipe #(
    parameter  int DATA_W = 4,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][DATA_W-1:0] d_q, d_d;
    logic [DEPTH-1:0]             r;
    logic [DEPTH-1:0]             src_v;
    logic [DEPTH-1:0][DATA_W-1:0] src_d;
    logic                         hole;

    // Ready ripples from the output: a stage can load if any stage at or after it frees up.
    always_comb begin
        hole = out_ready;
        r    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hole = hole | ~v_q[k];
            r[k] = hole;
        end
    end

    always_comb begin
        src_v    = '0;
        src_d    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v_q[k-1];
            src_d[k] = d_q[k-1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (r[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    d_d[k] = src_d[k];
                end
            end
        end
        // Flush drops every word but leaves the data registers untouched.
        if (flush) begin
            v_d = '0;
            d_d = d_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CNT_W'(v_q[k]);
        end
    end

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v_q[DEPTH-1] & ~flush;
    assign out_data  = d_q[DEPTH-1];

endmodule
